// File: rtl/alu_pkg.sv
// Shared widths, opcode map and shifter direction type for the datapath ALU.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int OPRN_W  = 6;
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [OPRN_W-1:0] OP_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] OP_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] OP_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] OP_SRL = 6'h04;
  localparam logic [OPRN_W-1:0] OP_SLL = 6'h05;
  localparam logic [OPRN_W-1:0] OP_AND = 6'h06;
  localparam logic [OPRN_W-1:0] OP_OR  = 6'h07;
  localparam logic [OPRN_W-1:0] OP_NOR = 6'h08;
  localparam logic [OPRN_W-1:0] OP_SLT = 6'h09;

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_t;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter, zero fill, result forced to 0 once the amount reaches DATA_W.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] amount,
  input  shift_dir_t        dir,
  output logic [DATA_W-1:0] result
);

  logic              saturate;
  logic [DATA_W-1:0] stage;

  // Any set bit above the low SHAMT_W bits means the amount is >= DATA_W.
  assign saturate = |amount[DATA_W-1:SHAMT_W];

  // NOTE: combinational blocks use blocking assignments so each stage sees the
  // previous stage's value within the same evaluation; every output gets a default first.
  always_comb begin
    stage = data;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (amount[i]) begin
        if (dir == SHIFT_LEFT) stage = stage << (1 << i);
        else                   stage = stage >> (1 << i);
      end
    end
    result = saturate ? '0 : stage;
  end

endmodule

// File: rtl/alu.sv
// Single-cycle 32-bit ALU with registered result and zero flag (one-cycle latency).
module alu
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] OP1,
  input  logic [DATA_W-1:0] OP2,
  input  logic [OPRN_W-1:0] OPRN,
  output logic [DATA_W-1:0] OUT,
  output logic              ZERO
);

  logic              sub_mode;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] shifted;
  logic              less;
  shift_dir_t        shift_dir;
  logic [DATA_W-1:0] next_out;
  logic              next_zero;

  // One adder serves add and sub: subtract is OP1 + ~OP2 + 1.
  assign sub_mode = (OPRN == OP_SUB);
  assign addend   = sub_mode ? ~OP2 : OP2;
  assign sum      = OP1 + addend + {{(DATA_W-1){1'b0}}, sub_mode};

  // Assignment width keeps only the low DATA_W bits of the product.
  assign product  = OP1 * OP2;

  assign less      = (OP1 < OP2);
  assign shift_dir = (OPRN == OP_SLL) ? SHIFT_LEFT : SHIFT_RIGHT;

  alu_shifter u_shifter (
    .data   (OP1),
    .amount (OP2),
    .dir    (shift_dir),
    .result (shifted)
  );

  always_comb begin
    next_out = '0;
    case (OPRN)
      OP_ADD, OP_SUB: next_out = sum;
      OP_MUL:         next_out = product;
      OP_SRL, OP_SLL: next_out = shifted;
      OP_AND:         next_out = OP1 & OP2;
      OP_OR:          next_out = OP1 | OP2;
      OP_NOR:         next_out = ~(OP1 | OP2);
      OP_SLT:         next_out = {{(DATA_W-1){1'b0}}, less};
      default:        next_out = '0;
    endcase
    next_zero = (next_out == '0);
  end

  // NOTE: state registers use non-blocking assignments, and the reset branch
  // gives every register a defined value (ZERO resets to 1 to agree with OUT=0).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT  <= '0;
      ZERO <= 1'b1;
    end else begin
      OUT  <= next_out;
      ZERO <= next_zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the ALU plus hand-written reset and hold sequences.
module tb_alu;
  import alu_pkg::*;

  logic              CLK;
  logic              RST;
  logic [DATA_W-1:0] OP1;
  logic [DATA_W-1:0] OP2;
  logic [OPRN_W-1:0] OPRN;
  logic [DATA_W-1:0] OUT;
  logic              ZERO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [OPRN_W-1:0] oprn;
    logic [DATA_W-1:0] exp_out;
    logic              exp_zero;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .CLK  (CLK),
    .RST  (RST),
    .OP1  (OP1),
    .OP2  (OP2),
    .OPRN (OPRN),
    .OUT  (OUT),
    .ZERO (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [OPRN_W-1:0] op, input logic [DATA_W-1:0] eo,
                              input logic ez);
    vec_t v;
    v.op1 = a; v.op2 = b; v.oprn = op; v.exp_out = eo; v.exp_zero = ez;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] actual,
                       input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string name, input logic [DATA_W-1:0] eo, input logic ez);
    check({name, "_out"}, OUT, eo);
    check({name, "_zero"}, {31'b0, ZERO}, {31'b0, ez});
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic apply(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [OPRN_W-1:0] op);
    @(negedge CLK);
    OP1 = a; OP2 = b; OPRN = op;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Arithmetic
    vecs.push_back(mk(32'd15, 32'd3, OP_ADD, 32'd18, 1'b0));
    vecs.push_back(mk(32'd15, 32'd5, OP_SUB, 32'd10, 1'b0));
    vecs.push_back(mk(32'd15, 32'd5, OP_MUL, 32'd75, 1'b0));
    vecs.push_back(mk(32'd15, 32'd0, OP_MUL, 32'd0, 1'b1));
    vecs.push_back(mk(32'd5, 32'd15, OP_SUB, 32'hFFFF_FFF6, 1'b0));
    // Shifts and logic
    vecs.push_back(mk(32'd15, 32'd5, OP_SRL, 32'd0, 1'b1));
    vecs.push_back(mk(32'd15, 32'd5, OP_SLL, 32'd480, 1'b0));
    vecs.push_back(mk(32'd15, 32'd5, OP_AND, 32'd5, 1'b0));
    vecs.push_back(mk(32'd15, 32'd5, OP_OR, 32'd15, 1'b0));
    vecs.push_back(mk(32'd15, 32'd5, OP_NOR, 32'hFFFF_FFF0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'd40, OP_SRL, 32'd0, 1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'd31, OP_SRL, 32'd1, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h8000_0001, OP_SRL, 32'd0, 1'b1));
    vecs.push_back(mk(32'd1, 32'd31, OP_SLL, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(32'd1, 32'd32, OP_SLL, 32'd0, 1'b1));
    vecs.push_back(mk(32'h1234_5678, 32'd0, OP_SLL, 32'h1234_5678, 1'b0));
    // Unsigned set-less-than
    vecs.push_back(mk(32'd15, 32'd5, OP_SLT, 32'd0, 1'b1));
    vecs.push_back(mk(32'd5, 32'd15, OP_SLT, 32'd1, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd0, 1'b1));
    vecs.push_back(mk(32'd7, 32'd7, OP_SLT, 32'd0, 1'b1));
    // Wrap-around
    vecs.push_back(mk(32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1'b1));
    vecs.push_back(mk(32'd0, 32'd1, OP_SUB, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(32'h0001_0000, 32'h0001_0000, OP_MUL, 32'd0, 1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 32'd1, 1'b0));
    // Undefined opcodes
    vecs.push_back(mk(32'd15, 32'd3, 6'h00, 32'd0, 1'b1));
    vecs.push_back(mk(32'd15, 32'd3, 6'h3F, 32'd0, 1'b1));
    vecs.push_back(mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 6'h0A, 32'd0, 1'b1));

    // Reset state without any clock edge
    RST = 1'b1; OP1 = 32'd15; OP2 = 32'd3; OPRN = OP_ADD;
    #2;
    check_outputs("reset_initial", 32'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset_held", 32'd0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op1, vecs[i].op2, vecs[i].oprn);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero);
    end

    // Inputs changing between edges do not disturb the held result
    apply(32'd15, 32'd3, OP_ADD);
    check_outputs("hold_before", 32'd18, 1'b0);
    @(negedge CLK);
    OP1 = 32'd0; OP2 = 32'd0; OPRN = OP_OR;
    #2;
    check_outputs("hold_between_edges", 32'd18, 1'b0);

    // Asynchronous reset mid-operation, held across edges, then released
    OP1 = 32'd15; OP2 = 32'd3; OPRN = OP_ADD;
    @(posedge CLK);
    #1;
    check_outputs("pre_reset", 32'd18, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check_outputs("async_reset", 32'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset_across_edges", 32'd0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    OP1 = 32'd5; OP2 = 32'd15; OPRN = OP_SUB;
    #1;
    check_outputs("released_no_edge", 32'd0, 1'b1);
    @(posedge CLK);
    #1;
    check_outputs("first_edge_after_release", 32'hFFFF_FFF6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
